// File: rtl/sid_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Package : sid_pkg
// Brief   : Shared widths and decimator FSM encoding for the SID audio path.
// Rev     : 1.0
// ---------------------------------------------------------------------------
package sid_pkg;

  localparam int SID_AUDIO_W    = 18;
  localparam int DEC_OUT_W      = 16;
  localparam int DEC_CNT_W      = 6;
  localparam int DEC_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    DEC_IDLE = 2'd0,
    DEC_DIV  = 2'd1,
    DEC_SIGN = 2'd2,
    DEC_PUSH = 2'd3
  } dec_state_t;

endpackage
`default_nettype wire

// File: rtl/sid_sample_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : sid_sample_fifo
// Brief  : Synchronous first-word-fall-through FIFO; head reads 0 when empty.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module sid_sample_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    push,
  input  logic [W-1:0]            push_data,
  input  logic                    pop,
  output logic [W-1:0]            head,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int c_aw = $clog2(DEPTH);

  logic [W-1:0]    r_mem [DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw:0]   r_level;
  logic            w_do_push;
  logic            w_do_pop;

  assign empty     = (r_level == '0);
  assign full      = r_level[c_aw];
  assign w_do_pop  = pop & ~empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

  assign head  = empty ? '0 : r_mem[r_rd_ptr];
  assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/sid_sample_decimator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : sid_sample_decimator
// Brief  : Box-car decimator for sid_top audio, exact divide, FIFO'd output.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module sid_sample_decimator
  import sid_pkg::*;
#(
  parameter int IN_W       = SID_AUDIO_W,
  parameter int OUT_W      = DEC_OUT_W,
  parameter int CNT_W      = DEC_CNT_W,
  parameter int FIFO_DEPTH = DEC_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         ce_1m,
  input  logic [IN_W-1:0]              audio_in,
  input  logic [15:0]                  rate_inc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_W-1:0]             out_data,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         overrun
);

  localparam int                    c_acc_w     = IN_W + CNT_W;
  localparam int                    c_iter_w    = $clog2(c_acc_w);
  localparam logic [c_iter_w-1:0]   c_iter_last = c_iter_w'(c_acc_w - 1);

  dec_state_t          r_state;
  dec_state_t          w_state_nxt;
  logic [c_acc_w-1:0]  r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic [15:0]         r_phase;
  logic [c_acc_w-1:0]  r_dq;
  logic [CNT_W-1:0]    r_rem;
  logic [CNT_W:0]      r_div;
  logic                r_neg;
  logic [c_iter_w-1:0] r_iter;
  logic [OUT_W-1:0]    r_result;
  logic                r_overrun;

  logic [c_acc_w-1:0]  w_sum;
  logic [c_acc_w-1:0]  w_sum_abs;
  logic [CNT_W:0]      w_n;
  logic [16:0]         w_phase_sum;
  logic                w_emit;
  logic                w_snap_take;
  logic                w_snap_drop;
  logic [CNT_W:0]      w_trial;
  logic [CNT_W:0]      w_diff;
  logic                w_qbit;
  logic [c_acc_w-1:0]  w_q_signed;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic                w_unused;

  assign w_sum       = r_acc + {{CNT_W{audio_in[IN_W-1]}}, audio_in};
  assign w_sum_abs   = w_sum[c_acc_w-1] ? -w_sum : w_sum;
  assign w_n         = {1'b0, r_cnt} + 1'b1;
  assign w_phase_sum = {1'b0, r_phase} + {1'b0, rate_inc};
  assign w_emit      = w_phase_sum[16] | w_n[CNT_W];
  assign w_snap_take = ce_1m & w_emit & (r_state == DEC_IDLE);
  assign w_snap_drop = ce_1m & w_emit & (r_state != DEC_IDLE);

  // Restoring division: remainder stays below the divisor (<= 2**CNT_W).
  assign w_trial     = {r_rem, r_dq[c_acc_w-1]};
  assign w_qbit      = (w_trial >= r_div);
  assign w_diff      = w_trial - r_div;
  assign w_q_signed  = r_neg ? -r_dq : r_dq;

  assign w_pop       = out_valid & out_ready;
  assign w_unused    = ^{w_q_signed[c_acc_w-1:IN_W], w_q_signed[IN_W-OUT_W-1:0], w_diff[CNT_W]};

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= DEC_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    case (r_state)
      DEC_IDLE: if (w_snap_take) w_state_nxt = DEC_DIV;
      DEC_DIV:  if (r_iter == c_iter_last) w_state_nxt = DEC_SIGN;
      DEC_SIGN: w_state_nxt = DEC_PUSH;
      DEC_PUSH: begin
        w_push      = 1'b1;
        w_state_nxt = DEC_IDLE;
      end
      default:  w_state_nxt = DEC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_phase <= '0;
    end else if (ce_1m) begin
      r_phase <= w_phase_sum[15:0];
      if (w_emit) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= w_n[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_dq     <= '0;
      r_rem    <= '0;
      r_div    <= '0;
      r_neg    <= 1'b0;
      r_iter   <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        DEC_IDLE: if (w_snap_take) begin
          r_dq   <= w_sum_abs;
          r_div  <= w_n;
          r_neg  <= w_sum[c_acc_w-1];
          r_rem  <= '0;
          r_iter <= '0;
        end
        DEC_DIV: begin
          r_dq   <= {r_dq[c_acc_w-2:0], w_qbit};
          r_rem  <= w_qbit ? w_diff[CNT_W-1:0] : w_trial[CNT_W-1:0];
          r_iter <= r_iter + 1'b1;
        end
        DEC_SIGN: r_result <= w_q_signed[IN_W-1:IN_W-OUT_W];
        default:  r_result <= r_result;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)                                          r_overrun <= 1'b0;
    else if (w_snap_drop | (w_push & w_full & ~w_pop))     r_overrun <= 1'b1;
  end

  sid_sample_fifo #(
    .W     (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (w_push),
    .push_data (r_result),
    .pop       (w_pop),
    .head      (out_data),
    .full      (w_full),
    .empty     (w_empty),
    .level     (fifo_level)
  );

  assign out_valid = ~w_empty;
  assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sid_sample_decimator.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// Module : tb_sid_sample_decimator
// Brief  : Table-driven vectors plus scoreboard for the sample decimator.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module tb_sid_sample_decimator;

  localparam int CE_GAP = 32;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ce_1m;
  logic [17:0] audio_in;
  logic [15:0] rate_inc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  fifo_level;
  logic        overrun;

  int          n_pass  = 0;
  int          n_total = 0;
  int          rx_count;
  logic [15:0] last_data;
  logic [15:0] sb_q[$];

  int          m_sum;
  int          m_n;
  logic [15:0] m_phase;

  typedef struct {
    logic [15:0] rate;
    logic [17:0] a;
    logic [17:0] b;
    int          n_ce;
    int          exp_emits;
    logic [15:0] exp_last;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  sid_sample_decimator dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ce_1m      (ce_1m),
    .audio_in   (audio_in),
    .rate_inc   (rate_inc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .fifo_level (fifo_level),
    .overrun    (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard consumer: each accepted transfer is matched to the oldest prediction.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_output: got %0h expected none", out_data);
      end else begin
        check("sb_data", {16'h0, out_data}, {16'h0, sb_q.pop_front()});
      end
      rx_count++;
      last_data = out_data;
    end
  end

  task automatic model_reset();
    m_sum   = 0;
    m_n     = 0;
    m_phase = '0;
    sb_q.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
  endtask

  task automatic drive_ce(input logic [17:0] s);
    logic [16:0] p;
    logic [17:0] q;
    int          sx;
    int          avg;
    audio_in = s;
    ce_1m    = 1'b1;
    sx       = $signed(s);
    m_sum   += sx;
    m_n++;
    p        = {1'b0, m_phase} + {1'b0, rate_inc};
    m_phase  = p[15:0];
    if (p[16] || m_n == 64) begin
      avg   = m_sum / m_n;
      q     = avg[17:0];
      sb_q.push_back(q[17:2]);
      m_sum = 0;
      m_n   = 0;
    end
    @(posedge clk);
    #1 ce_1m = 1'b0;
  endtask

  task automatic run_ce(input logic [17:0] s, input int count);
    for (int i = 0; i < count; i++) begin
      drive_ce(s);
      repeat (CE_GAP - 1) @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((sb_q.size() != 0 || out_valid) && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    check({name, "_drain"}, sb_q.size(), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h0C78, 18'h04000, 18'h04000, 200,  9, 16'h1000};
    vecs[1] = '{16'h0000, 18'h1FFFF, 18'h3FFFF, 192,  3, 16'h3FFF};
    vecs[2] = '{16'h0000, 18'h3FFFB, 18'h3FFFB, 128,  2, 16'hFFFE};
    vecs[3] = '{16'h2000, 18'h20000, 18'h20000,  64,  8, 16'h8000};
    vecs[4] = '{16'hFFFF, 18'h1FFFF, 18'h00001,  20, 19, 16'h0000};

    reset_n   = 1'b0;
    ce_1m     = 1'b0;
    audio_in  = '0;
    rate_inc  = '0;
    out_ready = 1'b0;
    rx_count  = 0;
    last_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_level", fifo_level, 0);
    check("rst_overrun", overrun, 0);
    @(posedge clk);
    #1;

    for (int v = 0; v < 5; v++) begin
      do_reset();
      rate_inc  = vecs[v].rate;
      out_ready = 1'b1;
      rx_count  = 0;
      for (int i = 0; i < vecs[v].n_ce; i++)
        run_ce((i % 2 == 0) ? vecs[v].a : vecs[v].b, 1);
      drain($sformatf("vec%0d", v));
      check($sformatf("vec%0d_emits", v), rx_count, vecs[v].exp_emits);
      check($sformatf("vec%0d_last", v), last_data, vecs[v].exp_last);
      check($sformatf("vec%0d_overrun", v), overrun, 0);
    end

    // Backpressure: four fill the FIFO, the 5th and 6th results are dropped.
    do_reset();
    rate_inc  = 16'h2000;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) run_ce(18'(32'h400 * (k + 1)), 8);
    check("bp_level4", fifo_level, 4);
    check("bp_no_overrun", overrun, 0);
    check("bp_valid", out_valid, 1);
    check("bp_head", out_data, 16'h0100);
    run_ce(18'h01400, 8);
    run_ce(18'h01800, 8);
    void'(sb_q.pop_back());
    void'(sb_q.pop_back());
    check("bp_level_full", fifo_level, 4);
    check("bp_overrun", overrun, 1);
    check("bp_head_held", out_data, 16'h0100);
    rx_count  = 0;
    out_ready = 1'b1;
    drain("bp");
    check("bp_pops", rx_count, 4);
    check("bp_valid_drop", out_valid, 0);
    check("bp_overrun_sticky", overrun, 1);

    // Push coinciding with a pop while full.
    do_reset();
    rate_inc  = 16'h2000;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) run_ce(18'(32'h400 * (k + 1)), 8);
    check("pp_level4", fifo_level, 4);
    run_ce(18'h01400, 7);
    drive_ce(18'h01400);
    repeat (25) @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("pp_level", fifo_level, 4);
    check("pp_overrun", overrun, 0);
    check("pp_head", out_data, 16'h0200);
    out_ready = 1'b1;
    drain("pp");
    check("pp_empty", fifo_level, 0);

    // Reset while the divider is busy.
    do_reset();
    rate_inc  = 16'h2000;
    out_ready = 1'b1;
    run_ce(18'h00800, 7);
    drive_ce(18'h00800);
    repeat (10) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
    check("mr_valid", out_valid, 0);
    check("mr_level", fifo_level, 0);
    check("mr_overrun", overrun, 0);
    rx_count = 0;
    run_ce(18'h00C00, 8);
    drain("mr");
    check("mr_count", rx_count, 1);
    check("mr_data", last_data, 16'h0300);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
